usb_packet_rx: RTL and testbench

Receive-side packet parser for the full-speed USB device core. It is the counterpart of the descriptor transmitter. It takes the decoded, de-stuffed bit stream together with a bit strobe and an EOP pulse. It hunts SYNC, captures and checks the PID, extracts token fields (CRC5) and data payload (CRC16), then reports one summary per packet. Its outputs drive the request decoder and the transmit-side sequencing (PID history, descriptor selection).

---
 rtl/usb_pkg.sv | 35 +++
 rtl/usb_crc_serial.sv | 30 +++
 rtl/usb_packet_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_usb_packet_rx.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB constants: PID values, CRC polynomials/residuals, receiver states.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // Consecutive zeros that must precede the closing 1 of SYNC
  localparam logic [2:0] SYNC_ZEROS = 3'd6;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_PID     = 3'd1,
    ST_TOKEN   = 3'd2,
    ST_DATA    = 3'd3,
    ST_WAITEOP = 3'd4
  } rx_state_e;

  // PID byte is good when the check nibble is the complement and it is not a special PID
  function automatic logic pid_byte_ok(input logic [7:0] b);
    return (b[7:4] == ~b[3:0]) && (b[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC register, MSB-first shift with feedback polynomial POLY.
module usb_crc_serial #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] crc_o
);
  logic [WIDTH-1:0] crc_q;
  logic             fb;

  assign fb    = crc_q[WIDTH-1] ^ bit_i;
  assign crc_o = crc_q;

  // Reload on clear, otherwise fold one bit in per shift strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= INIT;
    end else if (clear_i) begin
      crc_q <= INIT;
    end else if (shift_i) begin
      crc_q <= {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end
endmodule

// File: rtl/usb_packet_rx.sv
// Full-speed USB receive packet parser: SYNC hunt, PID check, token/data field
// extraction with CRC5/CRC16, and a one-cycle summary after each EOP.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HUNT    | counting zeros, waiting for the SYNC-closing 1
// ST_PID     | shifting the 8 PID bits
// ST_TOKEN   | shifting 16 token bits through CRC5
// ST_DATA    | shifting payload + CRC16, two-byte holdoff before emit
// ST_WAITEOP | discarding bits until EOP (handshake, bad PID, overflow)
module usb_packet_rx
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       check_data_i,
  input  logic       rx_bit_i,
  input  logic       rx_eop_i,
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  output logic       pkt_done_o,
  output logic [3:0] pkt_pid_o,
  output logic       pkt_ok_o,
  output logic       pid_err_o,
  output logic       crc_err_o,
  output logic       len_err_o,
  output logic [6:0] tok_addr_o,
  output logic [3:0] tok_endp_o,
  output logic [6:0] byte_count_o
);
  // Bytes allowed on the wire after the PID: payload plus the two CRC16 bytes
  localparam logic [7:0] BYTE_LIMIT = 8'(MAX_BYTES + 2);

  rx_state_e   state_q;
  logic [2:0]  zero_cnt_q;
  logic [4:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [10:0] tok_q;
  logic [7:0]  byte_cnt_q;
  logic [6:0]  emit_cnt_q;
  logic [7:0]  hold0_q;
  logic [7:0]  hold1_q;
  logic [1:0]  hold_cnt_q;
  logic [3:0]  pid_q;
  logic        hand_q;
  logic        pid_acc_q;
  logic        len_acc_q;

  logic        bit_ev;
  logic [7:0]  byte_d;
  logic        crc_clear;
  logic        crc5_shift;
  logic        crc16_shift;
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic        eop_pid_err;
  logic        eop_crc_err;
  logic        eop_len_err;

  // EOP wins over a coincident bit strobe
  assign bit_ev      = check_data_i & ~rx_eop_i;
  assign byte_d      = {rx_bit_i, shift_q[7:1]};
  assign crc_clear   = (state_q == ST_HUNT);
  assign crc5_shift  = bit_ev && (state_q == ST_TOKEN) && (bit_cnt_q != 5'd16);
  assign crc16_shift = bit_ev && (state_q == ST_DATA);

  usb_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(5'h1F)) u_crc5 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(crc_clear),
    .shift_i(crc5_shift),
    .bit_i  (rx_bit_i),
    .crc_o  (crc5)
  );

  usb_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(16'hFFFF)) u_crc16 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(crc_clear),
    .shift_i(crc16_shift),
    .bit_i  (rx_bit_i),
    .crc_o  (crc16)
  );

  // Error verdict for a packet whose EOP arrives in the current state
  always_comb begin
    eop_pid_err = pid_acc_q;
    eop_crc_err = 1'b0;
    eop_len_err = len_acc_q;
    case (state_q)
      ST_PID:   eop_pid_err = 1'b1;
      ST_TOKEN: begin
        eop_len_err = (bit_cnt_q != 5'd16);
        eop_crc_err = (crc5 != CRC5_RESIDUAL);
      end
      ST_DATA:  begin
        eop_len_err = (bit_cnt_q[2:0] != 3'd0) || (byte_cnt_q < 8'd2);
        eop_crc_err = (crc16 != CRC16_RESIDUAL);
      end
      default: ;
    endcase
  end

  // Receive FSM with registered summary and byte outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_HUNT;
      zero_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tok_q        <= '0;
      byte_cnt_q   <= '0;
      emit_cnt_q   <= '0;
      hold0_q      <= '0;
      hold1_q      <= '0;
      hold_cnt_q   <= '0;
      pid_q        <= '0;
      hand_q       <= 1'b0;
      pid_acc_q    <= 1'b0;
      len_acc_q    <= 1'b0;
      byte_data_o  <= '0;
      byte_valid_o <= 1'b0;
      pkt_done_o   <= 1'b0;
      pkt_pid_o    <= '0;
      pkt_ok_o     <= 1'b0;
      pid_err_o    <= 1'b0;
      crc_err_o    <= 1'b0;
      len_err_o    <= 1'b0;
      tok_addr_o   <= '0;
      tok_endp_o   <= '0;
      byte_count_o <= '0;
    end else begin
      byte_valid_o <= 1'b0;
      pkt_done_o   <= 1'b0;
      if (rx_eop_i) begin
        // EOP while hunting is line noise; anywhere else it closes a packet
        if (state_q != ST_HUNT) begin
          pkt_done_o   <= 1'b1;
          pkt_pid_o    <= (state_q == ST_PID) ? 4'h0 : pid_q;
          pid_err_o    <= eop_pid_err;
          crc_err_o    <= eop_crc_err;
          len_err_o    <= eop_len_err;
          pkt_ok_o     <= ~(eop_pid_err | eop_crc_err | eop_len_err);
          byte_count_o <= emit_cnt_q;
          if (state_q == ST_TOKEN) begin
            tok_addr_o <= tok_q[6:0];
            tok_endp_o <= tok_q[10:7];
          end
          hold_cnt_q <= '0;
          state_q    <= ST_HUNT;
        end
      end else if (bit_ev) begin
        case (state_q)
          ST_HUNT: begin
            if (!rx_bit_i) begin
              if (zero_cnt_q != SYNC_ZEROS) zero_cnt_q <= zero_cnt_q + 3'd1;
            end else if (zero_cnt_q == SYNC_ZEROS) begin
              state_q    <= ST_PID;
              zero_cnt_q <= '0;
              bit_cnt_q  <= '0;
              byte_cnt_q <= '0;
              emit_cnt_q <= '0;
              hold_cnt_q <= '0;
              hand_q     <= 1'b0;
              pid_acc_q  <= 1'b0;
              len_acc_q  <= 1'b0;
            end else begin
              zero_cnt_q <= '0;
            end
          end
          ST_PID: begin
            shift_q   <= byte_d;
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              pid_q     <= byte_d[3:0];
              bit_cnt_q <= '0;
              if (!pid_byte_ok(byte_d)) begin
                pid_acc_q <= 1'b1;
                state_q   <= ST_WAITEOP;
              end else if (byte_d[1:0] == 2'b01) begin
                state_q <= ST_TOKEN;
              end else if (byte_d[1:0] == 2'b11) begin
                state_q <= ST_DATA;
              end else begin
                hand_q  <= 1'b1;
                state_q <= ST_WAITEOP;
              end
            end
          end
          ST_TOKEN: begin
            if (bit_cnt_q == 5'd16) begin
              len_acc_q <= 1'b1;
              state_q   <= ST_WAITEOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q < 5'd11) tok_q <= {rx_bit_i, tok_q[10:1]};
            end
          end
          ST_DATA: begin
            shift_q   <= byte_d;
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q[2:0] == 3'd7) begin
              byte_cnt_q <= byte_cnt_q + 8'd1;
              if (byte_cnt_q == BYTE_LIMIT) begin
                len_acc_q <= 1'b1;
                state_q   <= ST_WAITEOP;
              end else begin
                // The two newest bytes may be the CRC, so only the third-newest leaves
                hold0_q <= byte_d;
                hold1_q <= hold0_q;
                if (hold_cnt_q == 2'd2) begin
                  byte_data_o  <= hold1_q;
                  byte_valid_o <= 1'b1;
                  emit_cnt_q   <= emit_cnt_q + 7'd1;
                end else begin
                  hold_cnt_q <= hold_cnt_q + 2'd1;
                end
              end
            end
          end
          ST_WAITEOP: begin
            if (hand_q) len_acc_q <= 1'b1;
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_packet_rx.sv
// Scoreboard bench for usb_packet_rx: random and directed packets, expectations
// from a reflected-CRC reference model, checked by an independent monitor.
module tb_usb_packet_rx;
  import usb_pkg::*;

  localparam int MAX_BYTES = 64;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [3:0] pid;
    bit         pe;
    bit         ce;
    bit         le;
    bit         tok;
    logic [6:0] addr;
    logic [3:0] endp;
    int         cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       check_data = 1'b0;
  logic       rx_bit = 1'b0;
  logic       rx_eop = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       pkt_done;
  logic [3:0] pkt_pid;
  logic       pkt_ok;
  logic       pid_err;
  logic       crc_err;
  logic       len_err;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic [6:0] byte_count;

  int checks = 0;
  int errors = 0;
  byte unsigned exp_bytes[$];
  exp_t         exp_pkts[$];
  exp_t         me;
  byte unsigned mb;

  always #5 clk = ~clk;

  usb_packet_rx #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .check_data_i(check_data),
    .rx_bit_i    (rx_bit),
    .rx_eop_i    (rx_eop),
    .byte_data_o (byte_data),
    .byte_valid_o(byte_valid),
    .pkt_done_o  (pkt_done),
    .pkt_pid_o   (pkt_pid),
    .pkt_ok_o    (pkt_ok),
    .pid_err_o   (pid_err),
    .crc_err_o   (crc_err),
    .len_err_o   (len_err),
    .tok_addr_o  (tok_addr),
    .tok_endp_o  (tok_endp),
    .byte_count_o(byte_count)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit pid_ok(input byte unsigned p);
    return (p[7:4] == ~p[3:0]) && (p[1:0] != 2'b00);
  endfunction

  // Reflected (LSB-first) CRC5 over 11 field bits, complemented as transmitted
  function automatic logic [4:0] crc5_ref(input logic [10:0] f);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) c = (c[0] ^ f[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return ~c;
  endfunction

  // Reflected CRC16 over whole bytes, complemented; sent low byte first
  function automatic logic [15:0] crc16_ref(input bq_t d);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[i]) begin
      c = c ^ {8'h00, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_exp(input logic [3:0] pid, input bit pe, input bit ce, input bit le,
                          input bit tok, input int cnt);
    exp_t e;
    e = '{default: 0};
    e.pid = pid; e.pe = pe; e.ce = ce; e.le = le; e.tok = tok; e.cnt = cnt;
    exp_pkts.push_back(e);
  endtask

  // b[0] is the PID byte; extra = loose bits appended after the bytes
  task automatic model_push(input bq_t b, input int extra);
    exp_t         e;
    int           nbits;
    int           n;
    byte unsigned p;
    logic [15:0]  w;
    bq_t          pl;
    e = '{default: 0};
    pl = {};
    nbits = 8 * b.size() + extra;
    p = b[0];
    e.pid = p[3:0];
    if (!pid_ok(p)) begin
      e.pe = 1;
    end else if (p[1:0] == 2'b10) begin
      e.le = (nbits > 8);
    end else if (p[1:0] == 2'b01) begin
      if (nbits != 24) begin
        e.le = 1;
      end else begin
        w = {b[2], b[1]};
        e.tok = 1;
        e.addr = w[6:0];
        e.endp = w[10:7];
        e.ce = (crc5_ref(w[10:0]) != w[15:11]);
      end
    end else begin
      n = b.size() - 1;
      if (n > MAX_BYTES + 2) begin
        e.le = 1;
        for (int i = 1; i <= MAX_BYTES; i++) exp_bytes.push_back(b[i]);
        e.cnt = MAX_BYTES;
      end else begin
        for (int i = 1; i <= n - 2; i++) begin
          pl.push_back(b[i]);
          exp_bytes.push_back(b[i]);
        end
        e.cnt = n - 2;
        e.ce = (crc16_ref(pl) != {b[n], b[n-1]});
      end
    end
    exp_pkts.push_back(e);
  endtask

  task automatic send_bit(input bit b);
    check_data = 1'b1;
    rx_bit = b;
    @(posedge clk); #1;
    check_data = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input byte unsigned v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_eop();
    rx_eop = 1'b1;
    check_data = 1'($urandom_range(0, 1));
    rx_bit = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    rx_eop = 1'b0;
    check_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Junk before SYNC: never six zeros followed by a one
  task automatic send_prefix();
    int k;
    k = $urandom_range(0, 8);
    for (int i = 0; i < k; i++) send_bit((i % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1)));
  endtask

  task automatic send_pkt(input bq_t b, input int extra);
    send_prefix();
    send_byte(8'h80);
    foreach (b[i]) send_byte(b[i]);
    for (int i = 0; i < extra; i++) send_bit(1'($urandom_range(0, 1)));
    send_eop();
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_byte_data"}, 32'(byte_data), 0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 0);
    chk({tag, "_pkt_pid"}, 32'(pkt_pid), 0);
    chk({tag, "_pkt_ok"}, 32'(pkt_ok), 0);
    chk({tag, "_pid_err"}, 32'(pid_err), 0);
    chk({tag, "_crc_err"}, 32'(crc_err), 0);
    chk({tag, "_len_err"}, 32'(len_err), 0);
    chk({tag, "_tok_addr"}, 32'(tok_addr), 0);
    chk({tag, "_tok_endp"}, 32'(tok_endp), 0);
    chk({tag, "_byte_count"}, 32'(byte_count), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a byte or a summary
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        if (exp_bytes.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte actual=%0h expected=none", byte_data);
        end else begin
          mb = exp_bytes.pop_front();
          chk("byte_data", 32'(byte_data), 32'(mb));
        end
      end
      if (pkt_done) begin
        if (exp_pkts.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pkt_done actual_pid=%0h expected=none", pkt_pid);
        end else begin
          me = exp_pkts.pop_front();
          chk("pkt_pid", 32'(pkt_pid), 32'(me.pid));
          chk("pid_err", 32'(pid_err), 32'(me.pe));
          chk("crc_err", 32'(crc_err), 32'(me.ce));
          chk("len_err", 32'(len_err), 32'(me.le));
          chk("pkt_ok", 32'(pkt_ok), 32'(!(me.pe || me.ce || me.le)));
          chk("byte_count", 32'(byte_count), 32'(me.cnt));
          chk("byte_valid_at_done", 32'(byte_valid), 0);
          if (me.tok) begin
            chk("tok_addr", 32'(tok_addr), 32'(me.addr));
            chk("tok_endp", 32'(tok_endp), 32'(me.endp));
          end
        end
      end
    end
  end

  logic [3:0]  tok_pids[4]  = '{PID_OUT, PID_IN, PID_SOF, PID_SETUP};
  logic [3:0]  hs_pids[3]   = '{PID_ACK, PID_NAK, PID_STALL};
  logic [3:0]  data_pids[2] = '{PID_DATA0, PID_DATA1};

  initial begin
    bq_t          b;
    bq_t          pl;
    int           extra;
    int           kind;
    int           len;
    int           j;
    logic [3:0]   pid;
    logic [10:0]  f;
    logic [15:0]  w;
    logic [15:0]  c;
    byte unsigned p;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // SETUP addr 0 endp 0
    b = '{8'h2D, 8'h00, 8'h10};
    push_exp(4'hD, 0, 0, 0, 1, 0);
    send_pkt(b, 0);

    // DATA0 GET_DESCRIPTOR-style payload, good and corrupted CRC
    b = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    for (int i = 1; i <= 8; i++) exp_bytes.push_back(b[i]);
    push_exp(4'h3, 0, 0, 0, 0, 8);
    send_pkt(b, 0);
    b[10] = 8'h95;
    for (int i = 1; i <= 8; i++) exp_bytes.push_back(b[i]);
    push_exp(4'h3, 0, 1, 0, 0, 8);
    send_pkt(b, 0);

    // ACK, then a PID with a broken check nibble
    b = '{8'hD2};
    push_exp(4'h2, 0, 0, 0, 0, 0);
    send_pkt(b, 0);
    b = '{8'hD3};
    push_exp(4'h3, 1, 0, 0, 0, 0);
    send_pkt(b, 0);

    // IN token with a 17th bit
    b = '{8'h69, 8'h00, 8'h10};
    push_exp(4'h9, 0, 0, 1, 0, 0);
    send_pkt(b, 1);

    // EOP after only four PID bits
    push_exp(4'h0, 1, 0, 0, 0, 0);
    send_byte(8'h80);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    send_eop();

    // Stray EOP while hunting: no summary expected
    send_eop();

    // Overflow: MAX_BYTES+3 bytes after the PID
    pl = {};
    for (int i = 0; i < MAX_BYTES + 1; i++) pl.push_back(8'($urandom));
    c = crc16_ref(pl);
    b = pl;
    b.push_front({~PID_DATA1, PID_DATA1});
    b.push_back(c[7:0]);
    b.push_back(c[15:8]);
    model_push(b, 0);
    send_pkt(b, 0);

    // Reset mid-DATA after two bytes have left the holdoff
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22);
    send_byte(8'h80);
    send_byte({~PID_DATA0, PID_DATA0});
    foreach (b[i]) send_byte(b[i]);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    check_zero("in_reset");
    rst_n = 1'b1;
    check_zero("after_reset");
    b = '{8'h2D, 8'h00, 8'h10};
    push_exp(4'hD, 0, 0, 0, 1, 0);
    send_pkt(b, 0);

    // Randomized traffic through the reference model
    for (int t = 0; t < 30; t++) begin
      b = {};
      extra = 0;
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) send_eop();
      case (kind)
        0: begin
          pid = tok_pids[$urandom_range(0, 3)];
          f = 11'($urandom);
          w = {crc5_ref(f), f};
          if ($urandom_range(0, 3) == 0) begin
            j = $urandom_range(0, 15);
            w[j] = ~w[j];
          end
          b.push_back({~pid, pid});
          b.push_back(w[7:0]);
          b.push_back(w[15:8]);
          if ($urandom_range(0, 7) == 0) extra = 1;
        end
        1: begin
          pid = data_pids[$urandom_range(0, 1)];
          j = $urandom_range(0, 9);
          len = (j == 0) ? MAX_BYTES + 1 : (j == 1) ? MAX_BYTES : $urandom_range(0, 12);
          pl = {};
          for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
          c = crc16_ref(pl);
          b = pl;
          b.push_front({~pid, pid});
          b.push_back(c[7:0]);
          b.push_back(c[15:8]);
          if ($urandom_range(0, 3) == 0) begin
            j = $urandom_range(1, b.size() - 1);
            b[j] = b[j] ^ 8'(1 << $urandom_range(0, 7));
          end
        end
        2: begin
          pid = hs_pids[$urandom_range(0, 2)];
          b.push_back({~pid, pid});
          if ($urandom_range(0, 3) == 0) extra = $urandom_range(1, 3);
        end
        default: begin
          do p = 8'($urandom); while (pid_ok(p));
          b.push_back(p);
          repeat ($urandom_range(0, 2)) b.push_back(8'($urandom));
        end
      endcase
      model_push(b, extra);
      send_pkt(b, extra);
    end

    for (int i = 0; i < 200 && (exp_pkts.size() != 0 || exp_bytes.size() != 0); i++)
      @(posedge clk);
    chk("leftover_pkts", exp_pkts.size(), 0);
    chk("leftover_bytes", exp_bytes.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
